// File: rtl/rr_grant_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_arbiter_if
// Description : Request/grant bundle between N requesters and rr_grant_arbiter.
//               timeout_o exists only when ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_grant_arbiter_if #(
    parameter int N = 8
);
    localparam int IDX_W = $clog2(N);

    logic             enable;
    logic [N-1:0]     req_i;
    logic [N-1:0]     grant_o;
    logic [IDX_W-1:0] grant_idx_o;
    logic             grant_valid_o;
`ifdef ARB_TIMEOUT_EN
    logic             timeout_o;
`endif

    modport master (
        output enable,
        output req_i,
        input  grant_o,
        input  grant_idx_o,
`ifdef ARB_TIMEOUT_EN
        input  timeout_o,
`endif
        input  grant_valid_o
    );

    modport slave (
        input  enable,
        input  req_i,
        output grant_o,
        output grant_idx_o,
`ifdef ARB_TIMEOUT_EN
        output timeout_o,
`endif
        output grant_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_arbiter
// Description : Round-robin arbiter with registered one-hot grant, binary index
//               and owner lock. Optional hold timeout via ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
    parameter int N = 8
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 16
`endif
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rr_grant_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] c_PTR_INIT = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   c_N        = (IDX_W + 1)'(N);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [N-1:0]     r_grant;
    logic             r_valid;

    logic             w_owner_req;
    logic             w_expire;
    logic [N-1:0]     w_cand;
    logic [2*N-1:0]   w_dbl;
    logic [IDX_W:0]   w_shamt;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;
    logic             w_found;
    logic [IDX_W-1:0] w_winner;

    function automatic logic [N-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign w_owner_req = bus.req_i[r_idx];

`ifdef ARB_TIMEOUT_EN
    localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);

    logic [c_HOLD_W-1:0] r_hold;
    logic                r_timeout;

    assign w_expire      = (r_state == ST_GRANTED) && w_owner_req && (r_hold == c_HOLD_LAST);
    assign bus.timeout_o = r_timeout;
`else
    assign w_expire = 1'b0;
`endif

    // On expiry the current owner is masked out so the search lands on someone else.
    assign w_cand  = w_expire ? (bus.req_i & ~r_grant) : bus.req_i;
    assign w_found = |w_cand;

    // Rotate candidates so bit 0 is ptr+1; the doubled vector makes the wrap at N-1.
    assign w_dbl   = {w_cand, w_cand};
    assign w_shamt = {1'b0, r_ptr} + (IDX_W + 1)'(1);
    assign w_rot   = N'(w_dbl >> w_shamt);

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign w_sum    = w_shamt + {1'b0, w_off};
    assign w_winner = (w_sum >= c_N) ? IDX_W'(w_sum - c_N) : IDX_W'(w_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= c_PTR_INIT;
`ifdef ARB_TIMEOUT_EN
            r_hold    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (!bus.enable) begin
                r_state <= ST_IDLE;
                r_grant <= '0;
                r_valid <= 1'b0;
            end else if ((r_state == ST_GRANTED) && w_owner_req && !w_expire) begin
`ifdef ARB_TIMEOUT_EN
                r_hold <= r_hold + 1'b1;
`endif
            end else if (w_found) begin
                r_state <= ST_GRANTED;
                r_grant <= f_onehot(w_winner);
                r_idx   <= w_winner;
                r_valid <= 1'b1;
                r_ptr   <= w_winner;
`ifdef ARB_TIMEOUT_EN
                r_hold    <= '0;
                r_timeout <= w_expire;
`endif
            end else if (w_expire) begin
                // Nobody else waiting: owner keeps the grant with a fresh budget.
`ifdef ARB_TIMEOUT_EN
                r_hold <= '0;
`endif
            end else begin
                r_state <= ST_IDLE;
                r_grant <= '0;
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.grant_o       = r_grant;
    assign bus.grant_idx_o   = r_idx;
    assign bus.grant_valid_o = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_arbiter
// Description : Self-checking bench for rr_grant_arbiter (vectors, corner
//               sequences, randomized run against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam bit c_TO_ON   = 1'b1;
`else
    localparam bit c_TO_ON   = 1'b0;
`endif
    localparam int c_HOLD8   = 16;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    rr_grant_arbiter_if #(.N(8)) bus8 ();
    rr_grant_arbiter_if #(.N(5)) bus5 ();

`ifdef ARB_TIMEOUT_EN
    rr_grant_arbiter_if #(.N(8)) bust ();
    rr_grant_arbiter #(.N(8), .MAX_HOLD(c_HOLD8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    rr_grant_arbiter #(.N(5), .MAX_HOLD(16))      u_dut5 (.clk(clk), .rst(rst), .bus(bus5));
    rr_grant_arbiter #(.N(8), .MAX_HOLD(4))       u_dutt (.clk(clk), .rst(rst), .bus(bust));
`else
    rr_grant_arbiter #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    rr_grant_arbiter #(.N(5)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic [7:0] grant;
        logic       valid;
        logic [2:0] idx;
        logic       chk_idx;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic [7:0] q,
                                input logic [7:0] g, input logic v, input logic [2:0] ix,
                                input logic ci);
        vec_t t;
        t.rst = r; t.en = e; t.req = q; t.grant = g; t.valid = v; t.idx = ix; t.chk_idx = ci;
        vecs.push_back(t);
    endfunction

    // Reference model: owner as an integer, -1 when nobody holds the grant.
    int m_owner, m_ptr, m_cnt;
    bit m_to;

    function automatic int search(input logic [7:0] req, input int start, input int excl);
        for (int s = 0; s < 8; s++) begin
            int k;
            k = (start + s) % 8;
            if (k != excl && req[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [7:0] q);
        int k;
        m_to = 1'b0;
        if (r) begin
            m_owner = -1; m_ptr = 7; m_cnt = 0;
        end else if (!e) begin
            m_owner = -1;
        end else if (m_owner >= 0 && q[m_owner]) begin
            m_cnt++;
            if (c_TO_ON && m_cnt == c_HOLD8) begin
                m_cnt = 0;
                k = search(q, m_owner + 1, m_owner);
                if (k >= 0) begin
                    m_owner = k; m_ptr = k; m_to = 1'b1;
                end
            end
        end else begin
            k = search(q, m_ptr + 1, -1);
            if (k >= 0) begin
                m_owner = k; m_ptr = k; m_cnt = 0;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    initial begin
        logic [7:0] exp_g;
        logic [7:0] q;
        logic       e, r;

        rst = 1'b1;
        bus8.enable = 1'b1; bus8.req_i = '0;
        bus5.enable = 1'b1; bus5.req_i = '0;
`ifdef ARB_TIMEOUT_EN
        bust.enable = 1'b1; bust.req_i = '0;
`endif

        // Reset, then rotation with each owner dropping its bit one cycle after grant
        add(1, 1, 8'hFF, 8'h00, 0, 0, 1);
        add(1, 1, 8'hFF, 8'h00, 0, 0, 1);
        add(0, 1, 8'hFF, 8'h01, 1, 0, 1);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] rq;
            rq = ~(8'h01 << i);
            add(0, 1, rq, 8'h01 << ((i + 1) % 8), 1, 3'((i + 1) % 8), 1);
        end
        // Hold then release to next requester
        add(1, 1, 8'h00, 8'h00, 0, 0, 1);
        for (int i = 0; i < 10; i++) add(0, 1, 8'h24, 8'h04, 1, 2, 1);
        add(0, 1, 8'h20, 8'h20, 1, 5, 1);
        // Enable gate, rotation resumes after ptr=2
        add(1, 1, 8'h00, 8'h00, 0, 0, 1);
        add(0, 1, 8'h04, 8'h04, 1, 2, 1);
        add(0, 0, 8'h04, 8'h00, 0, 0, 0);
        add(0, 1, 8'h24, 8'h20, 1, 5, 1);
        // Idle, lone re-request, releasing owner loses to others
        add(0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 8'h20, 8'h20, 1, 5, 1);
        add(0, 1, 8'h01, 8'h01, 1, 0, 1);
        add(0, 1, 8'h21, 8'h01, 1, 0, 1);
        add(0, 1, 8'h20, 8'h20, 1, 5, 1);
        add(0, 1, 8'h21, 8'h20, 1, 5, 1);
        add(0, 1, 8'h01, 8'h01, 1, 0, 1);
        // Two requesters held: below any timeout the owner never changes
        add(1, 1, 8'h00, 8'h00, 0, 0, 1);
        for (int i = 0; i < 14; i++) add(0, 1, 8'h03, 8'h01, 1, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; bus8.enable = vecs[i].en; bus8.req_i = vecs[i].req;
            @(posedge clk); #1;
            check($sformatf("vec%0d grant", i), 32'(bus8.grant_o), 32'(vecs[i].grant));
            check($sformatf("vec%0d valid", i), 32'(bus8.grant_valid_o), 32'(vecs[i].valid));
            if (vecs[i].chk_idx)
                check($sformatf("vec%0d idx", i), 32'(bus8.grant_idx_o), 32'(vecs[i].idx));
        end

        // Wrap at N-1 for N=5: ptr=4 after reset
        @(negedge clk); rst = 1'b0; bus8.req_i = '0; bus5.req_i = 5'b00011;
        @(posedge clk); #1;
        check("wrap5 grant0", 32'(bus5.grant_o), 32'h01);
        check("wrap5 idx0",   32'(bus5.grant_idx_o), 32'd0);
        @(negedge clk); bus5.req_i = 5'b00010;
        @(posedge clk); #1;
        check("wrap5 grant1", 32'(bus5.grant_o), 32'h02);
        @(negedge clk); bus5.req_i = 5'b10000;
        @(posedge clk); #1;
        check("wrap5 grant4", 32'(bus5.grant_o), 32'h10);
        check("wrap5 idx4",   32'(bus5.grant_idx_o), 32'd4);
        @(negedge clk); bus5.req_i = 5'b00011;
        @(posedge clk); #1;
        check("wrap5 regrant0", 32'(bus5.grant_o), 32'h01);
        check("wrap5 reidx0",   32'(bus5.grant_idx_o), 32'd0);
        @(negedge clk); bus5.req_i = '0;

`ifdef ARB_TIMEOUT_EN
        // MAX_HOLD=4 with two requesters: alternate every 4 cycles, pulse on switch
        @(negedge clk); bust.req_i = 8'h03;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            check($sformatf("to c%0d grant", c), 32'(bust.grant_o),
                  (((c / 4) % 2) == 0) ? 32'h01 : 32'h02);
            check($sformatf("to c%0d pulse", c), 32'(bust.timeout_o),
                  32'((c > 0) && (c % 4 == 0)));
        end
        @(negedge clk); bust.req_i = '0;
`endif

        // Randomized run against the reference model
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            r = (n == 0) || ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 15) != 0);
            q = 8'($urandom) & 8'($urandom | $urandom);
            if (m_owner >= 0 && n > 0) begin
                if ($urandom_range(0, 4) != 0) q[m_owner] = 1'b1;
                else                           q[m_owner] = 1'b0;
            end
            rst = r; bus8.enable = e; bus8.req_i = q;
            model_step(r, e, q);
            @(posedge clk); #1;
            exp_g = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
            check($sformatf("rnd%0d grant", n), 32'(bus8.grant_o), 32'(exp_g));
            check($sformatf("rnd%0d valid", n), 32'(bus8.grant_valid_o), 32'(m_owner >= 0));
            if (m_owner >= 0)
                check($sformatf("rnd%0d idx", n), 32'(bus8.grant_idx_o), 32'(m_owner));
`ifdef ARB_TIMEOUT_EN
            check($sformatf("rnd%0d pulse", n), 32'(bus8.timeout_o), 32'(m_to));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
